mplc_dmem_arbiter: RTL and testbench
====================================

# mplc_dmem_arbiter

Round-robin access arbiter that lets NCORE logic cores share the single-port data word memory of the multi-core logic unit. Each cycle it selects at most one pending core request, drives the memory's address, write-enable and write-data inputs, and returns the read word to the granted core one cycle later. It sits directly upstream of the data word memory, between the core load/store ports and the memory.

## Interface
- NCORE, 4, number of requesting cores (2..8)
- AW, 16, address width (matches memory AW)
- DW, 32, data width (matches memory DW)

- CLK  in  1  system clock, rising edge
- NRST  in  1  asynchronous active-low reset
- REQ  in  NCORE  per-core access request, held until granted
- WE  in  NCORE  per-core write (1) / read (0) qualifier
- ADDR  in  NCORE*AW  per-core address, core i at [i*AW +: AW]
- WDATA  in  NCORE*DW  per-core write data, core i at [i*DW +: DW]
- LOCK  in  NCORE  per-core bus-lock request (used only with MPLC_ARB_LOCK_EN)
- GNT  out  NCORE  one-hot grant, combinational; access accepted at the next CLK edge
- RVALID  out  NCORE  one-hot read-data valid, registered
- RDATA  out  DW  read data, broadcast to all cores, qualified by RVALID
- M_WE  out  1  memory write enable
- M_A  out  AW  memory address
- M_DI  out  DW  memory write data
- M_DQ  in  DW  memory read data (valid the cycle after address capture)

## Operation
- Priority pointer PTR (0..NCORE-1): grant goes to the first core with REQ=1 searching PTR, PTR+1, ... modulo NCORE.
- At most one GNT bit high per cycle; GNT=0 when no REQ or NRST=0.
- Granted core's ADDR/WDATA/WE drive M_A/M_DI/M_WE combinationally; M_WE = WE[g] & GNT[g]. No grant: M_WE=0, M_A/M_DI = core 0's fields (don't-care).
- On edge with a grant to core g: PTR <= (g+1) mod NCORE; if WE[g]=0, RVALID <= one-hot(g), else RVALID <= 0.
- No grant on an edge: PTR holds, RVALID <= 0.
- RDATA = M_DQ combinationally; core consumes it only in its RVALID cycle.
- Core must keep REQ/WE/ADDR/WDATA stable until it sees GNT; may issue a new request the cycle after GNT (back-to-back allowed).
- Write and read from different cores never share a cycle; one transaction per cycle.

## Timing
- Reset (async assert): PTR=0, RVALID=0, lock owner cleared; GNT=0, M_WE=0 while NRST=0.
- Grant latency: 0 cycles (same cycle as REQ when PTR favours the core or no contention).
- Read latency: RVALID/RDATA exactly 1 cycle after the granting edge.
- Write: memory updated at the granting edge; read of same address in the next grant returns new data.
- Worst-case wait for a continuously requesting core: NCORE-1 cycles (no lock).
- Reset mid-read: pending RVALID dropped; no data returned.
- PTR wrap: grant to core NCORE-1 sets PTR=0.

## Configuration
- MPLC_ARB_LOCK_EN defined: granted access with LOCK[g]=1 sets owner=g, locked=1; while locked only core g may be granted (others see GNT=0 regardless of PTR); owner's next granted access with LOCK[g]=0 clears locked after that access. PTR updates normally. Enables atomic read-modify-write.
- MPLC_ARB_LOCK_EN undefined: LOCK ignored, no owner register; pure round-robin.

## Test plan
- Reset then single read: core 1 REQ, WE=0, ADDR=2, memory holds 800 at 2 -> GNT=4'b0010 same cycle, RVALID=4'b0010 and RDATA=800 next cycle.
- All four cores REQ continuously from reset -> GNT sequence 0001,0010,0100,1000,0001; PTR wraps.
- Core 2 writes 32'h1234 to address 5, core 3 reads address 5 in following cycle -> RVALID=4'b1000, RDATA=32'h1234.
- Core 0 read granted, NRST pulsed low before next edge -> RVALID stays 0, PTR=0, GNT=0 during reset.
- Idle cycle (REQ=0) between grants -> M_WE=0, RVALID=0, PTR unchanged.
- With MPLC_ARB_LOCK_EN: core 1 locked read of address 3 (value 500), cores 0,2 requesting -> next grant to core 1 only; core 1 writes 501 with LOCK=0 -> lock released, next grant goes to core 2.

Source files
------------

// File: rtl/mplc_dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data word memory among NCORE cores.
// Optional bus lock for atomic read-modify-write: define MPLC_ARB_LOCK_EN.
module mplc_dmem_arbiter #(
    parameter int NCORE = 4,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic                CLK,
    input  logic                NRST,
    input  logic [NCORE-1:0]    REQ,
    input  logic [NCORE-1:0]    WE,
    input  logic [NCORE*AW-1:0] ADDR,
    input  logic [NCORE*DW-1:0] WDATA,
    input  logic [NCORE-1:0]    LOCK,
    output logic [NCORE-1:0]    GNT,
    output logic [NCORE-1:0]    RVALID,
    output logic [DW-1:0]       RDATA,
    output logic                M_WE,
    output logic [AW-1:0]       M_A,
    output logic [DW-1:0]       M_DI,
    input  logic [DW-1:0]       M_DQ
);

    localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NCORE - 1);

    logic [PW-1:0]    ptr_r;
    logic [NCORE-1:0] rvalid_r;
    logic [NCORE-1:0] lock_mask_s;
    logic [NCORE-1:0] elig_s;
    logic [NCORE-1:0] gnt_s;
    logic [PW-1:0]    gnt_idx_s;
    logic             gnt_any_s;
    logic [PW-1:0]    ptr_nxt_s;

    // Core index reached by stepping off positions past base, modulo NCORE.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= NCORE) ? PW'(sum - NCORE) : PW'(sum);
    endfunction

`ifdef MPLC_ARB_LOCK_EN
    logic [PW-1:0] owner_r;
    logic          locked_r;

    // While locked, only the owner is eligible.
    always_comb begin
        lock_mask_s = {NCORE{1'b1}};
        if (locked_r) begin
            lock_mask_s          = {NCORE{1'b0}};
            lock_mask_s[owner_r] = 1'b1;
        end else begin
            lock_mask_s = {NCORE{1'b1}};
        end
    end

    // Lock owner tracking: any granted access re-evaluates the lock from LOCK[g].
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            owner_r  <= '0;
            locked_r <= 1'b0;
        end else if (gnt_any_s) begin
            if (LOCK[gnt_idx_s]) begin
                owner_r  <= gnt_idx_s;
                locked_r <= 1'b1;
            end else begin
                locked_r <= 1'b0;
            end
        end
    end
`else
    logic unused_lock_s;

    assign lock_mask_s   = {NCORE{1'b1}};
    assign unused_lock_s = ^LOCK;
`endif

    assign elig_s = REQ & lock_mask_s & {NCORE{NRST}};

    // Search from PTR downward in offset so the nearest eligible core wins.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        for (int k = NCORE - 1; k >= 0; k--) begin
            gnt_idx_s = elig_s[rr_idx(ptr_r, k)] ? rr_idx(ptr_r, k) : gnt_idx_s;
            gnt_any_s = gnt_any_s | elig_s[rr_idx(ptr_r, k)];
        end
    end

    // One-hot grant vector and the pointer value following the granted core.
    always_comb begin
        gnt_s            = {NCORE{1'b0}};
        gnt_s[gnt_idx_s] = gnt_any_s;
        ptr_nxt_s        = (gnt_idx_s == LAST_IDX) ? {PW{1'b0}} : gnt_idx_s + PW'(1);
    end

    // Memory port mux; with no grant the index is 0, so core 0's fields pass through.
    always_comb begin
        M_WE = gnt_any_s & WE[gnt_idx_s];
        M_A  = ADDR[int'(gnt_idx_s) * AW +: AW];
        M_DI = WDATA[int'(gnt_idx_s) * DW +: DW];
    end

    // Pointer advance and read-valid pipeline stage.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            ptr_r    <= '0;
            rvalid_r <= '0;
        end else if (gnt_any_s) begin
            ptr_r    <= ptr_nxt_s;
            rvalid_r <= gnt_s & ~WE;
        end else begin
            rvalid_r <= '0;
        end
    end

    assign GNT    = gnt_s;
    assign RVALID = rvalid_r;
    assign RDATA  = M_DQ;

endmodule

// File: tb/tb_mplc_dmem_arbiter.sv
// Self-checking bench for mplc_dmem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-free round-robin reference model.
module tb_mplc_dmem_arbiter;

    localparam int NCORE = 4;
    localparam int AW    = 16;
    localparam int DW    = 32;

    logic                CLK = 1'b0;
    logic                NRST;
    logic [NCORE-1:0]    REQ;
    logic [NCORE-1:0]    WE;
    logic [NCORE*AW-1:0] ADDR;
    logic [NCORE*DW-1:0] WDATA;
    logic [NCORE-1:0]    LOCK;
    logic [NCORE-1:0]    GNT;
    logic [NCORE-1:0]    RVALID;
    logic [DW-1:0]       RDATA;
    logic                M_WE;
    logic [AW-1:0]       M_A;
    logic [DW-1:0]       M_DI;
    logic [DW-1:0]       M_DQ;

    mplc_dmem_arbiter #(.NCORE(NCORE), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .NRST(NRST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .LOCK(LOCK), .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA), .M_WE(M_WE),
        .M_A(M_A), .M_DI(M_DI), .M_DQ(M_DQ)
    );

    always #5 CLK = ~CLK;

    // Single-port memory: read-first, data out one cycle after address capture.
    logic [DW-1:0] mem [0:63];
    logic          mem_init;
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'd400;
            mem[3] <= 32'd500;
        end else begin
            if (M_WE) mem[M_A[5:0]] <= M_DI;
            M_DQ <= mem[M_A[5:0]];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        NRST = 1'b0;
        REQ  = '0;
        WE   = '0;
        LOCK = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        NRST = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [3:0]  gnt;
        logic        mwe;
        logic [3:0]  rv;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl [11];

    // Reference model state for the random phase
    logic [DW-1:0] ref_mem [0:15];
    int            ptr_m, owner_m, g, idx, a;
    bit            locked_m;
    logic [3:0]    exp_rv_m;
    logic [DW-1:0] exp_rd_m;
    int            wait_m [NCORE];

    initial begin
        mem_init = 1'b1;
        ADDR     = '0;
        WDATA    = '0;
        do_reset();
        mem_init = 1'b0;

        // Single read after reset: core 1, address 2 holds 800
        ADDR[1*AW +: AW] = 16'd2;
        REQ = 4'b0010;
        @(negedge CLK);
        chk("a_gnt", GNT, 4'b0010);
        chk("a_ma", M_A, 16'd2);
        chk("a_mwe", M_WE, 1'b0);
        tick();
        REQ = 4'b0000;
        @(negedge CLK);
        chk("a_rvalid", RVALID, 4'b0010);
        chk("a_rdata", RDATA, 32'd800);
        tick();

        // Vector table: rotation, wrap, idle cycle, contention, writes
        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0, 4'b0000, 32'd0};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 1'b0, 4'b0001, 32'd8000};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 1'b0, 4'b0010, 32'd8400};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 1'b0, 4'b0100, 32'd8800};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0, 4'b1000, 32'd9200};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 32'd8000};
        tbl[6]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0000, 32'd0};
        tbl[7]  = '{4'b1001, 4'b0000, 4'b1000, 1'b0, 4'b0000, 32'd0};
        tbl[8]  = '{4'b1001, 4'b0000, 4'b0001, 1'b0, 4'b1000, 32'd9200};
        tbl[9]  = '{4'b0110, 4'b0100, 4'b0010, 1'b0, 4'b0001, 32'h0000A000};
        tbl[10] = '{4'b0110, 4'b0100, 4'b0100, 1'b1, 4'b0010, 32'd8400};
        do_reset();
        ADDR  = {16'd23, 16'd22, 16'd21, 16'd20};
        WDATA = {32'h0000A003, 32'h0000A002, 32'h0000A001, 32'h0000A000};
        for (int r = 0; r < 11; r++) begin
            REQ = tbl[r].req;
            WE  = tbl[r].we;
            @(negedge CLK);
            chk("tbl_gnt", GNT, tbl[r].gnt);
            chk("tbl_mwe", M_WE, tbl[r].mwe);
            chk("tbl_rvalid", RVALID, tbl[r].rv);
            if (tbl[r].rv != 4'b0000) chk("tbl_rdata", RDATA, tbl[r].rd);
            tick();
        end
        REQ = '0;
        WE  = '0;

        // Write by core 2 then read of the same address by core 3
        ADDR[2*AW +: AW]  = 16'd5;
        WDATA[2*DW +: DW] = 32'h1234;
        ADDR[3*AW +: AW]  = 16'd5;
        REQ = 4'b0100;
        WE  = 4'b0100;
        @(negedge CLK);
        chk("b_gnt_w", GNT, 4'b0100);
        chk("b_mwe", M_WE, 1'b1);
        chk("b_ma", M_A, 16'd5);
        chk("b_mdi", M_DI, 32'h1234);
        tick();
        REQ = 4'b1000;
        WE  = 4'b0000;
        @(negedge CLK);
        chk("b_gnt_r", GNT, 4'b1000);
        chk("b_rvalid_w", RVALID, 4'b0000);
        tick();
        REQ = 4'b0000;
        @(negedge CLK);
        chk("b_rvalid", RVALID, 4'b1000);
        chk("b_rdata", RDATA, 32'h1234);
        tick();

        // Reset asserted while a read is in flight
        ADDR[0 +: AW] = 16'd2;
        REQ = 4'b0001;
        @(negedge CLK);
        chk("c_gnt", GNT, 4'b0001);
        tick();
        NRST = 1'b0;
        REQ  = 4'b1111;
        WE   = 4'b1111;
        #1;
        chk("c_rvalid_rst", RVALID, 4'b0000);
        chk("c_gnt_rst", GNT, 4'b0000);
        chk("c_mwe_rst", M_WE, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        chk("c_gnt_rst2", GNT, 4'b0000);
        NRST = 1'b1;
        WE   = 4'b0000;
        #1;
        chk("c_ptr0", GNT, 4'b0001);
        chk("c_rvalid_post", RVALID, 4'b0000);
        tick();
        REQ = '0;
        tick();

`ifdef MPLC_ARB_LOCK_EN
        // Locked read-modify-write by core 1 while cores 0 and 2 contend
        do_reset();
        ADDR[0 +: AW]     = 16'd2;
        ADDR[1*AW +: AW]  = 16'd3;
        WDATA[1*DW +: DW] = 32'd501;
        REQ = 4'b0001;
        tick();
        REQ  = 4'b0111;
        LOCK = 4'b0010;
        @(negedge CLK);
        chk("e_gnt_lock", GNT, 4'b0010);
        tick();
        REQ  = 4'b0101;
        LOCK = 4'b0000;
        @(negedge CLK);
        chk("e_gnt_blocked", GNT, 4'b0000);
        chk("e_rvalid", RVALID, 4'b0010);
        chk("e_rdata", RDATA, 32'd500);
        tick();
        REQ = 4'b0111;
        WE  = 4'b0010;
        @(negedge CLK);
        chk("e_gnt_owner", GNT, 4'b0010);
        chk("e_mwe", M_WE, 1'b1);
        tick();
        REQ = 4'b0101;
        WE  = 4'b0000;
        @(negedge CLK);
        chk("e_gnt_release", GNT, 4'b0100);
        tick();
        REQ = '0;
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'(32 + i) * 32'd400;
        do_reset();
        ptr_m    = 0;
        owner_m  = 0;
        locked_m = 1'b0;
        exp_rv_m = '0;
        exp_rd_m = '0;
        for (int i = 0; i < NCORE; i++) wait_m[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge CLK);
            g = -1;
            for (int k = 0; k < NCORE; k++) begin
                idx = (ptr_m + k) % NCORE;
                if (g < 0 && REQ[idx] && (!locked_m || owner_m == idx)) g = idx;
            end
            chk("rnd_gnt", GNT, (g >= 0) ? (4'b0001 << g) : 4'b0000);
            chk("rnd_rvalid", RVALID, exp_rv_m);
            if (exp_rv_m != 4'b0000) chk("rnd_rdata", RDATA, exp_rd_m);
            if (g >= 0) begin
                chk("rnd_mwe", M_WE, WE[g]);
                chk("rnd_ma", M_A, ADDR[g*AW +: AW]);
                if (WE[g]) chk("rnd_mdi", M_DI, WDATA[g*DW +: DW]);
`ifndef MPLC_ARB_LOCK_EN
                chk("rnd_wait", (wait_m[g] <= NCORE - 1), 1'b1);
`endif
            end else begin
                chk("rnd_mwe_idle", M_WE, 1'b0);
            end
            @(posedge CLK);
            for (int i = 0; i < NCORE; i++)
                if (REQ[i] && i != g) wait_m[i]++;
            if (g >= 0) begin
                a = int'(ADDR[g*AW +: AW]) - 32;
                if (WE[g]) begin
                    ref_mem[a] = WDATA[g*DW +: DW];
                    exp_rv_m   = 4'b0000;
                end else begin
                    exp_rv_m = 4'b0001 << g;
                    exp_rd_m = ref_mem[a];
                end
                ptr_m = (g + 1) % NCORE;
`ifdef MPLC_ARB_LOCK_EN
                if (LOCK[g]) begin
                    locked_m = 1'b1;
                    owner_m  = g;
                end else begin
                    locked_m = 1'b0;
                end
`endif
                wait_m[g] = 0;
            end else begin
                exp_rv_m = 4'b0000;
            end
            #1;
            if (g >= 0) REQ[g] = 1'b0;
            for (int i = 0; i < NCORE; i++) begin
                if (!REQ[i] && $urandom_range(0, 2) != 0) begin
                    REQ[i]              = 1'b1;
                    WE[i]               = 1'($urandom_range(0, 1));
                    LOCK[i]             = ($urandom_range(0, 3) == 0);
                    ADDR[i*AW +: AW]    = 16'(32 + $urandom_range(0, 15));
                    WDATA[i*DW +: DW]   = $urandom;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
